// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C register block: the register map, the CTRL bit
// positions and the STATUS bit positions.
package i2c_reg_pkg;

  typedef enum logic [7:0] {
    ADDR_CTRL     = 8'h00,
    ADDR_PRESCALE = 8'h01,
    ADDR_SLV_ADDR = 8'h02,
    ADDR_TX_DATA  = 8'h03,
    ADDR_RX_DATA  = 8'h04,
    ADDR_STATUS   = 8'h05
  } reg_addr_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_RW    = 2;
  localparam int CTRL_FLUSH = 7;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_ACK_ERR  = 5;
  localparam int STAT_TX_OVF   = 6;
  localparam int STAT_RX_OVF   = 7;

endpackage

// File: rtl/i2c_reg_if.sv
// Register access bus between the APB slave (master side) and the I2C register block (slave side).
interface i2c_reg_if;

  logic [7:0] REG_ADDR_i;
  logic [7:0] REG_WDATA_i;
  logic       REG_WR_EN_i;
  logic       REG_RD_EN_i;
  logic [7:0] REG_RDATA_o;

  modport master (
    output REG_ADDR_i, REG_WDATA_i, REG_WR_EN_i, REG_RD_EN_i,
    input  REG_RDATA_o
  );

  modport slave (
    input  REG_ADDR_i, REG_WDATA_i, REG_WR_EN_i, REG_RD_EN_i,
    output REG_RDATA_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with flush and an overflow pulse for pushes dropped while full.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf_pulse
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // When full, a requested pop always succeeds, which is what lets a same-cycle push in.
  assign doPop     = pop && !empty && !flush;
  assign doPush    = push && (!full || pop) && !flush;
  assign ovf_pulse = push && full && !pop && !flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rdPtr_q];

endmodule

// File: rtl/i2c_reg_block.sv
// Register block between the APB slave and the I2C master core: control/prescale/address
// registers, sticky status flags and the TX/RX byte FIFOs.
module i2c_reg_block
  import i2c_reg_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] PRESCALE_RST = 8'h04
) (
  input  logic       PCLK_i,
  input  logic       PRESET_N_i,
  i2c_reg_if.slave   reg_bus,
  output logic       ENABLE_o,
  output logic       START_o,
  output logic       RW_o,
  output logic [6:0] SLV_ADDR_o,
  output logic [7:0] PRESCALE_o,
  output logic [7:0] TX_DATA_o,
  output logic       TX_VALID_o,
  input  logic       TX_POP_i,
  input  logic [7:0] RX_DATA_i,
  input  logic       RX_PUSH_i,
  input  logic       BUSY_i,
  input  logic       ACK_ERR_i
);

  logic       enable_q, enable_d;
  logic       rw_q, rw_d;
  logic       start_q, start_d;
  logic [6:0] slvAddr_q, slvAddr_d;
  logic [7:0] prescale_q, prescale_d;
  logic       txOvf_q, txOvf_d;
  logic       rxOvf_q, rxOvf_d;
  logic       ackErr_q, ackErr_d;

  logic       wrCtrl, wrPrescale, wrSlvAddr, wrTxData, wrStatus, rdRxData;
  logic       flush;
  logic       txFull, txEmpty, txOvfPulse;
  logic       rxFull, rxEmpty, rxOvfPulse;
  logic [7:0] rxHead;
  logic [7:0] status;
  logic [7:0] wdata;

  assign wdata      = reg_bus.REG_WDATA_i;
  assign wrCtrl     = reg_bus.REG_WR_EN_i && (reg_bus.REG_ADDR_i == ADDR_CTRL);
  assign wrPrescale = reg_bus.REG_WR_EN_i && (reg_bus.REG_ADDR_i == ADDR_PRESCALE);
  assign wrSlvAddr  = reg_bus.REG_WR_EN_i && (reg_bus.REG_ADDR_i == ADDR_SLV_ADDR);
  assign wrTxData   = reg_bus.REG_WR_EN_i && (reg_bus.REG_ADDR_i == ADDR_TX_DATA);
  assign wrStatus   = reg_bus.REG_WR_EN_i && (reg_bus.REG_ADDR_i == ADDR_STATUS);
  assign rdRxData   = reg_bus.REG_RD_EN_i && (reg_bus.REG_ADDR_i == ADDR_RX_DATA);

  // Flush is decoded straight from the write so it lands on the same edge as the register update.
  assign flush = wrCtrl && wdata[CTRL_FLUSH];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK_i), .rst_n(PRESET_N_i), .flush(flush),
    .push(wrTxData), .pop(TX_POP_i), .din(wdata), .dout(TX_DATA_o),
    .full(txFull), .empty(txEmpty), .ovf_pulse(txOvfPulse)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK_i), .rst_n(PRESET_N_i), .flush(flush),
    .push(RX_PUSH_i), .pop(rdRxData), .din(RX_DATA_i), .dout(rxHead),
    .full(rxFull), .empty(rxEmpty), .ovf_pulse(rxOvfPulse)
  );

  always_comb begin
    enable_d   = enable_q;
    rw_d       = rw_q;
    slvAddr_d  = slvAddr_q;
    prescale_d = prescale_q;
    txOvf_d    = txOvf_q;
    rxOvf_d    = rxOvf_q;
    ackErr_d   = ackErr_q;
    start_d    = wrCtrl && wdata[CTRL_START] && wdata[CTRL_EN] && !BUSY_i;
    if (wrCtrl) begin
      enable_d = wdata[CTRL_EN];
      rw_d     = wdata[CTRL_RW];
    end
    if (wrPrescale) prescale_d = wdata;
    if (wrSlvAddr)  slvAddr_d  = wdata[6:0];
    // Clears are applied first so a same-cycle set event wins.
    if (wrStatus) begin
      if (wdata[STAT_RX_OVF])  rxOvf_d  = 1'b0;
      if (wdata[STAT_TX_OVF])  txOvf_d  = 1'b0;
      if (wdata[STAT_ACK_ERR]) ackErr_d = 1'b0;
    end
    if (rxOvfPulse) rxOvf_d  = 1'b1;
    if (txOvfPulse) txOvf_d  = 1'b1;
    if (ACK_ERR_i)  ackErr_d = 1'b1;
  end

  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      enable_q   <= 1'b0;
      rw_q       <= 1'b0;
      start_q    <= 1'b0;
      slvAddr_q  <= '0;
      prescale_q <= PRESCALE_RST;
      txOvf_q    <= 1'b0;
      rxOvf_q    <= 1'b0;
      ackErr_q   <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      rw_q       <= rw_d;
      start_q    <= start_d;
      slvAddr_q  <= slvAddr_d;
      prescale_q <= prescale_d;
      txOvf_q    <= txOvf_d;
      rxOvf_q    <= rxOvf_d;
      ackErr_q   <= ackErr_d;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_TX_EMPTY] = txEmpty;
    status[STAT_TX_FULL]  = txFull;
    status[STAT_RX_EMPTY] = rxEmpty;
    status[STAT_RX_FULL]  = rxFull;
    status[STAT_BUSY]     = BUSY_i;
    status[STAT_ACK_ERR]  = ackErr_q;
    status[STAT_TX_OVF]   = txOvf_q;
    status[STAT_RX_OVF]   = rxOvf_q;
  end

  always_comb begin
    reg_bus.REG_RDATA_o = '0;
    case (reg_bus.REG_ADDR_i)
      ADDR_CTRL:     reg_bus.REG_RDATA_o = {5'b0, rw_q, 1'b0, enable_q};
      ADDR_PRESCALE: reg_bus.REG_RDATA_o = prescale_q;
      ADDR_SLV_ADDR: reg_bus.REG_RDATA_o = {1'b0, slvAddr_q};
      ADDR_RX_DATA:  reg_bus.REG_RDATA_o = rxHead;
      ADDR_STATUS:   reg_bus.REG_RDATA_o = status;
      default:       reg_bus.REG_RDATA_o = '0;
    endcase
  end

  assign ENABLE_o   = enable_q;
  assign RW_o       = rw_q;
  assign START_o    = start_q;
  assign SLV_ADDR_o = slvAddr_q;
  assign PRESCALE_o = prescale_q;
  assign TX_VALID_o = !txEmpty;

endmodule

// File: tb/tb_i2c_reg_block.sv
// Bench for i2c_reg_block: directed register-map scenarios followed by random traffic,
// all checked against a queue-based model of the register map.
module tb_i2c_reg_block;

  localparam int DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       PRESET_N = 1'b0;
  logic       ENABLE, START, RW, TX_VALID, TX_POP, RX_PUSH, BUSY, ACK_ERR;
  logic [6:0] SLV_ADDR;
  logic [7:0] PRESCALE, TX_DATA, RX_DATA;

  int totalChecks = 0;
  int badChecks   = 0;

  logic       modEn, modRw, modStart, modTxOvf, modRxOvf, modAck;
  logic [6:0] modSlv;
  logic [7:0] modPre;
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];

  i2c_reg_if bus();

  i2c_reg_block #(.FIFO_DEPTH(DEPTH), .PRESCALE_RST(8'h04)) dut (
    .PCLK_i(PCLK), .PRESET_N_i(PRESET_N), .reg_bus(bus.slave),
    .ENABLE_o(ENABLE), .START_o(START), .RW_o(RW), .SLV_ADDR_o(SLV_ADDR),
    .PRESCALE_o(PRESCALE), .TX_DATA_o(TX_DATA), .TX_VALID_o(TX_VALID),
    .TX_POP_i(TX_POP), .RX_DATA_i(RX_DATA), .RX_PUSH_i(RX_PUSH),
    .BUSY_i(BUSY), .ACK_ERR_i(ACK_ERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    modEn = 0; modRw = 0; modStart = 0; modTxOvf = 0; modRxOvf = 0; modAck = 0;
    modSlv = '0; modPre = 8'h04;
    txQ.delete(); rxQ.delete();
  endtask

  function automatic logic [7:0] modelRead(input logic [7:0] a, input logic busyIn);
    case (a)
      8'h00: return {5'b0, modRw, 1'b0, modEn};
      8'h01: return modPre;
      8'h02: return {1'b0, modSlv};
      8'h04: return (rxQ.size() > 0) ? rxQ[0] : 8'h00;
      8'h05: return {modRxOvf, modTxOvf, modAck, busyIn,
                     rxQ.size() == DEPTH, rxQ.size() == 0,
                     txQ.size() == DEPTH, txQ.size() == 0};
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelStep(input logic [7:0] a, d, input logic wr, rd, txPop, rxPush,
                           input logic [7:0] rxd, input logic busyIn, ack);
    logic wasFull;
    modStart = wr && a == 8'h00 && d[1] && d[0] && !busyIn;
    if (wr && a == 8'h00) begin modEn = d[0]; modRw = d[2]; end
    if (wr && a == 8'h01) modPre = d;
    if (wr && a == 8'h02) modSlv = d[6:0];
    if (wr && a == 8'h05) begin
      if (d[7]) modRxOvf = 0;
      if (d[6]) modTxOvf = 0;
      if (d[5]) modAck = 0;
    end
    if (ack) modAck = 1;
    if (wr && a == 8'h00 && d[7]) begin
      txQ.delete(); rxQ.delete();
    end else begin
      wasFull = (txQ.size() == DEPTH);
      if (txPop && txQ.size() > 0) void'(txQ.pop_front());
      if (wr && a == 8'h03) begin
        if (wasFull && !txPop) modTxOvf = 1; else txQ.push_back(d);
      end
      wasFull = (rxQ.size() == DEPTH);
      if (rd && a == 8'h04 && rxQ.size() > 0) void'(rxQ.pop_front());
      if (rxPush) begin
        if (wasFull && !(rd && a == 8'h04)) modRxOvf = 1; else rxQ.push_back(rxd);
      end
    end
  endtask

  task automatic checkState();
    checkOutput("START_o", START, modStart);
    checkOutput("ENABLE_o", ENABLE, modEn);
    checkOutput("RW_o", RW, modRw);
    checkOutput("SLV_ADDR_o", SLV_ADDR, modSlv);
    checkOutput("PRESCALE_o", PRESCALE, modPre);
    checkOutput("TX_VALID_o", TX_VALID, txQ.size() > 0);
    checkOutput("TX_DATA_o", TX_DATA, (txQ.size() > 0) ? txQ[0] : 8'h00);
  endtask

  // One bus cycle: drive after the falling edge, check read data mid-cycle, check state after the rise.
  task automatic applyStimulus(input logic [7:0] a, d, input logic wr, rd, txPop, rxPush,
                               input logic [7:0] rxd, input logic busyIn, ack);
    @(negedge PCLK);
    bus.REG_ADDR_i = a; bus.REG_WDATA_i = d; bus.REG_WR_EN_i = wr; bus.REG_RD_EN_i = rd;
    TX_POP = txPop; RX_PUSH = rxPush; RX_DATA = rxd; BUSY = busyIn; ACK_ERR = ack;
    #1 checkOutput("REG_RDATA_o", bus.REG_RDATA_o, modelRead(a, busyIn));
    @(posedge PCLK);
    #1;
    modelStep(a, d, wr, rd, txPop, rxPush, rxd, busyIn, ack);
    checkState();
  endtask

  task automatic regWrite(input logic [7:0] a, d);
    applyStimulus(a, d, 1, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic regRead(input logic [7:0] a);
    applyStimulus(a, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic idleInputs(input logic [7:0] a);
    bus.REG_ADDR_i = a; bus.REG_WDATA_i = 0; bus.REG_WR_EN_i = 0; bus.REG_RD_EN_i = 0;
    TX_POP = 0; RX_PUSH = 0; RX_DATA = 0; BUSY = 0; ACK_ERR = 0;
  endtask

  initial begin
    logic [7:0] txBytes [4];
    logic [7:0] a, d;
    int op;
    txBytes[0] = 8'hA1; txBytes[1] = 8'hB2; txBytes[2] = 8'hC3; txBytes[3] = 8'hD4;
    idleInputs(8'h01);
    modelReset();

    // Reset values while held in reset.
    repeat (2) @(negedge PCLK);
    #1 checkOutput("rst PRESCALE rd", bus.REG_RDATA_o, 8'h04);
    bus.REG_ADDR_i = 8'h05;
    #1 checkOutput("rst STATUS rd", bus.REG_RDATA_o, 8'h05);
    checkOutput("rst ctrl outs", {START, ENABLE, RW, TX_VALID}, 4'b0000);
    checkOutput("rst TX_DATA", TX_DATA, 8'h00);
    @(negedge PCLK) PRESET_N = 1'b1;

    // Start pulse and enable.
    regWrite(8'h00, 8'h03);
    checkOutput("start pulse", START, 1'b1);
    regRead(8'h00);
    checkOutput("start one cycle", START, 1'b0);
    checkOutput("CTRL rd", bus.REG_RDATA_o, 8'h01);
    regWrite(8'h00, 8'h02);
    checkOutput("start needs enable", START, 1'b0);
    applyStimulus(8'h00, 8'h03, 1, 0, 0, 0, 8'h00, 1, 0);
    checkOutput("start dropped busy", START, 1'b0);

    // TX fill, overflow, drain in order.
    for (int i = 0; i < 4; i++) regWrite(8'h03, txBytes[i]);
    regRead(8'h05);
    checkOutput("tx_full", bus.REG_RDATA_o[1], 1'b1);
    regWrite(8'h03, 8'hE5);
    regRead(8'h05);
    checkOutput("tx_ovf", bus.REG_RDATA_o[6], 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("tx order", TX_DATA, txBytes[i]);
      applyStimulus(8'h05, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    end
    checkOutput("tx drained", TX_VALID, 1'b0);

    // RX single byte, empty read, then full push+pop.
    applyStimulus(8'h04, 8'h00, 0, 0, 0, 1, 8'h5A, 0, 0);
    checkOutput("rx head", bus.REG_RDATA_o, 8'h5A);
    regRead(8'h04);
    checkOutput("rx empty rd", bus.REG_RDATA_o, 8'h00);
    for (int i = 1; i <= 4; i++) applyStimulus(8'h05, 8'h00, 0, 0, 0, 1, 8'(i * 8'h11), 0, 0);
    applyStimulus(8'h04, 8'h00, 0, 1, 0, 1, 8'h55, 0, 0);
    checkOutput("rx full kept", bus.REG_RDATA_o, 8'h22);
    for (int i = 0; i < 4; i++) regRead(8'h04);

    // Sticky ack_err: set, clear, set-beats-clear.
    applyStimulus(8'h05, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1);
    checkOutput("ack_err set", bus.REG_RDATA_o[5], 1'b1);
    regWrite(8'h05, 8'hE0);
    checkOutput("w1c clear", bus.REG_RDATA_o[7:5], 3'b000);
    applyStimulus(8'h05, 8'hE0, 1, 0, 0, 0, 8'h00, 0, 1);
    checkOutput("set beats w1c", bus.REG_RDATA_o[5], 1'b1);

    // Flush empties TX the next cycle.
    regWrite(8'h03, 8'h11);
    regWrite(8'h03, 8'h22);
    regWrite(8'h00, 8'h80);
    checkOutput("flush tx empty", TX_VALID, 1'b0);

    // Asynchronous reset mid-fill.
    regWrite(8'h01, 8'h99);
    regWrite(8'h03, 8'h33);
    applyStimulus(8'h03, 8'h44, 1, 0, 0, 1, 8'h77, 0, 0);
    @(negedge PCLK);
    idleInputs(8'h05);
    #2 PRESET_N = 1'b0;
    #1;
    modelReset();
    checkOutput("async rst PRESCALE", PRESCALE, 8'h04);
    checkOutput("async rst STATUS", bus.REG_RDATA_o, 8'h05);
    checkOutput("async rst TX_VALID", TX_VALID, 1'b0);
    @(negedge PCLK) PRESET_N = 1'b1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) a = 8'hF3;
      d = 8'($urandom);
      if (a == 8'h00 && $urandom_range(0, 7) != 0) d[7] = 1'b0;
      op = $urandom_range(0, 2);
      applyStimulus(a, d, op == 0, op == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                    8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/i2c_reg_block.md
Name: i2c_reg_block

Overview:
- Register block directly downstream of the APB slave interface; decodes the 8-bit register address/data the APB slave produces and returns read data to it.
- Holds I2C master control, prescaler and target-address registers, a TX byte FIFO and an RX byte FIFO.
- Presents status and handshakes to the I2C master core.
- Sub-module sync_fifo is instantiated twice.

Parameters:
- FIFO_DEPTH, 4, entries per TX/RX FIFO; power of two, minimum 2.
- PRESCALE_RST, 8'h04, reset value of the PRESCALE register.

Ports:
- PCLK_i  in  1  clock
- PRESET_N_i  in  1  asynchronous active-low reset
- REG_ADDR_i  in  8  register address from the APB slave
- REG_WDATA_i  in  8  write data from the APB slave
- REG_WR_EN_i  in  1  one-cycle write strobe from the APB slave
- REG_RD_EN_i  in  1  one-cycle read strobe from the APB slave; side-effect reads pop on this strobe
- REG_RDATA_o  out  8  read data, combinational on REG_ADDR_i
- ENABLE_o  out  1  core enable (CTRL[0])
- START_o  out  1  one-cycle start request
- RW_o  out  1  transfer direction, 1 = read (CTRL[2])
- SLV_ADDR_o  out  7  I2C target address
- PRESCALE_o  out  8  SCL prescaler
- TX_DATA_o  out  8  TX FIFO head
- TX_VALID_o  out  1  TX FIFO not empty
- TX_POP_i  in  1  core consumed TX head
- RX_DATA_i  in  8  received byte
- RX_PUSH_i  in  1  core pushes RX_DATA_i
- BUSY_i  in  1  core transfer in progress
- ACK_ERR_i  in  1  one-cycle NACK event from the core

Behaviour:
- Register map:
  - 0x00 CTRL (RW): [0] enable, [1] start (write-only, reads 0), [2] rw, [7] flush (write-only, reads 0); other bits read 0.
  - 0x01 PRESCALE (RW).
  - 0x02 SLV_ADDR (RW) [6:0]; bit 7 reads 0.
  - 0x03 TX_DATA: a write pushes the TX FIFO; reads return 0.
  - 0x04 RX_DATA: reads return the RX head (0x00 if empty); REG_RD_EN_i pops it.
  - 0x05 STATUS: {rx_ovf, tx_ovf, ack_err, busy, rx_full, rx_empty, tx_full, tx_empty}, bit 7..0. Writing 1 to bits 7:5 clears them; other write bits are ignored.
  - Unmapped addresses: reads return 0x00, writes are ignored.
- Reset values: ENABLE_o, RW_o, START_o = 0; SLV_ADDR_o = 0; PRESCALE_o = PRESCALE_RST; both FIFOs empty (TX_VALID_o = 0, TX_DATA_o = 0); all sticky flags = 0. Reset takes effect immediately mid-transfer and discards FIFO contents.
- Register writes update the register the cycle after REG_WR_EN_i (registered).
- START_o is high exactly one cycle, the cycle after a CTRL write with bit1 = 1 and bit0 = 1. If bit0 = 0 in the same write, no pulse. If BUSY_i = 1 at the write, no pulse and tx_ovf is unaffected (start is dropped).
- Flush: empties both FIFOs the cycle after the write and overrides any push or pop in that same cycle. Sticky flags are unchanged.
- FIFO rules (both FIFOs):
  - Push when full without a simultaneous pop: data dropped, the matching ovf flag sets.
  - Push and pop together when full: both occur, count unchanged.
  - Pop when empty: ignored.
  - Push and pop together when empty: push only.
- Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- ack_err sets on ACK_ERR_i. If set and W1C occur in the same cycle, set wins.
- busy bit mirrors BUSY_i combinationally.

Decomposition:
- Shared package i2c_reg_pkg holds:
  - address constants ADDR_CTRL..ADDR_STATUS;
  - CTRL bit indices (CTRL_EN, CTRL_START, CTRL_RW, CTRL_FLUSH);
  - STATUS bit indices.
- Sub-module sync_fifo holds the FIFO storage and logic:
  - parameters WIDTH and DEPTH;
  - ports clk, rst_n, flush, push, pop, din, dout, full, empty, ovf_pulse.
  - It is reused for TX and RX.

Test Plan:
- Reset: check PRESCALE reads 0x04, STATUS reads 0x05 (both FIFOs empty), all control outputs 0.
- Write CTRL = 0x03 -> START_o high exactly one cycle, ENABLE_o = 1, CTRL reads 0x01. Then write CTRL = 0x02 -> no START_o pulse.
- TX FIFO:
  - Write 0xA1, 0xB2, 0xC3, 0xD4 to TX_DATA -> tx_full = 1.
  - A fifth write of 0xE5 -> tx_ovf = 1.
  - Pulse TX_POP_i four times -> TX_DATA_o shows A1, B2, C3, D4 in order, then TX_VALID_o = 0.
- RX FIFO and simultaneous events:
  - Push 0x5A via RX_PUSH_i, then read RX_DATA -> 0x5A, rx_empty = 1; a further read returns 0x00.
  - With the FIFO full, push and pop in the same cycle -> count unchanged and order preserved.
- Sticky flags:
  - ACK_ERR_i pulse -> STATUS[5] = 1.
  - Write STATUS = 0xE0 -> bits 7:5 clear.
  - W1C write in the same cycle as an ACK_ERR_i pulse -> bit 5 stays 1.
- Flush and reset:
  - Fill TX with 2 entries, write CTRL = 0x80 -> tx_empty = 1 the next cycle.
  - Assert PRESET_N_i low mid-fill -> FIFOs empty and PRESCALE = 0x04 immediately, without waiting for a clock edge.
